// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch buffer: response error codes
// and the default instruction substituted on any fetch error.
package imem_pkg;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_BOTH     = 2'b11
   } err_e;

   localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_buf_if.sv
// Fetch, response and program-load signals between the fetch buffer
// (slave) and whatever drives it (master).
interface imem_fetch_buf_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32
);

   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              req_valid;
   logic              req_ready;
   logic [PC_W-1:0]   req_pc;
   logic              flush;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [1:0]        rsp_err;

   modport master (
      output load_en, load_addr, load_data, req_valid, req_pc, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_err
   );

   modport slave (
      input  load_en, load_addr, load_data, req_valid, req_pc, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_err
   );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one write port and one registered read port. Contents
// are never reset; a read in the same edge as a write returns the old word.
module imem_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
      if (re_i)
         rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_buf.sv
// Instruction fetch buffer: checks fetch addresses, issues one-cycle reads to
// imem_array and queues responses in a 2-entry FIFO with bypass.
module imem_fetch_buf
   import imem_pkg::*;
#(
   parameter int              DATA_W = 32,
   parameter int              ADDR_W = 5,
   parameter int              PC_W   = 32,
   parameter logic [DATA_W-1:0] NOP  = DATA_W'(DEFAULT_NOP)
) (
   input  logic             clk,
   input  logic             rst_n,
   imem_fetch_buf_if.slave  bus
);

   typedef struct packed {
      err_e              err;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic [1:0]        count_q, count_d;
   logic              inflight_q;
   err_e              inflightErr_q;
   entry_t            slot0_q, slot0_d;
   entry_t            slot1_q, slot1_d;

   logic [DATA_W-1:0] rdata;
   logic [PC_W-1:0]   pcHigh;
   logic              misalign, outOfRange, readyInt, accept;
   logic              bypass, pushEn, popEn;
   err_e              reqErr;
   entry_t            inflightEnt, head;

   assign pcHigh     = bus.req_pc >> (ADDR_W + 2);
   assign misalign   = bus.req_pc[1:0] != 2'b00;
   assign outOfRange = pcHigh != '0;
   assign reqErr     = err_e'({outOfRange, misalign});

   // Responses held in the FIFO plus the read in flight never exceed two.
   assign readyInt = rst_n && !bus.load_en && !bus.flush &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
   assign accept   = bus.req_valid && readyInt;

   imem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (bus.load_en && rst_n),
      .waddr_i (bus.load_addr),
      .wdata_i (bus.load_data),
      .re_i    (accept),
      .raddr_i (bus.req_pc[ADDR_W+1:2]),
      .rdata_o (rdata)
   );

   // The in-flight read is presented directly when the FIFO is empty, giving
   // one-cycle latency; otherwise it is queued behind the older entries.
   assign inflightEnt.err   = inflightErr_q;
   assign inflightEnt.instr = (inflightErr_q == ERR_OK) ? rdata : NOP;
   assign head              = (count_q != 2'd0) ? slot0_q : inflightEnt;

   assign bypass = inflight_q && (count_q == 2'd0) && bus.rsp_ready;
   assign pushEn = inflight_q && !bypass;
   assign popEn  = (count_q != 2'd0) && bus.rsp_ready;

   always_comb begin
      count_d = count_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case ({pushEn, popEn})
         2'b10: begin
            if (count_q == 2'd0)
               slot0_d = inflightEnt;
            else
               slot1_d = inflightEnt;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            slot0_d = (count_q == 2'd1) ? inflightEnt : slot1_q;
            slot1_d = inflightEnt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         inflight_q <= accept;
         slot0_q    <= slot0_d;
         slot1_q    <= slot1_d;
         if (accept)
            inflightErr_q <= reqErr;
      end
   end

   assign bus.req_ready = readyInt;
   assign bus.rsp_valid = (count_q != 2'd0) || inflight_q;
   assign bus.rsp_instr = bus.rsp_valid ? head.instr : NOP;
   assign bus.rsp_err   = bus.rsp_valid ? head.err : ERR_OK;

endmodule

// File: doc/imem_fetch_buf.md
IMEM_FETCH_BUF -- requirements
Module: imem_fetch_buf

Interface
REQ-001 Parameter DATA_W, default 32: instruction width in bits.
REQ-002 Parameter ADDR_W, default 5: word-index width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter PC_W, default 32: fetch byte-address width; PC_W SHALL be at least ADDR_W+2.
REQ-004 Parameter NOP, default 32'h0000_0000: instruction returned on any error.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 load_en  in  1  program-load write strobe.
REQ-008 load_addr  in  ADDR_W  word index for the load write.
REQ-009 load_data  in  DATA_W  word written on load.
REQ-010 req_valid  in  1  fetch request present.
REQ-011 req_ready  out  1  block accepts a fetch this cycle.
REQ-012 req_pc  in  PC_W  fetch byte address.
REQ-013 flush  in  1  discard all buffered and in-flight responses.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer takes the response this cycle.
REQ-016 rsp_instr  out  DATA_W  fetched instruction.
REQ-017 rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 misaligned and out of range.

Function
REQ-018 The block SHALL accept a fetch on any cycle where req_valid and req_ready are both 1.
REQ-019 Word index SHALL be req_pc[ADDR_W+1:2]; misaligned SHALL mean req_pc[1:0] != 0; out of range SHALL mean req_pc[PC_W-1:ADDR_W+2] != 0.
REQ-020 An accepted fetch SHALL appear at the response buffer head exactly 1 cycle later, through a registered synchronous read.
REQ-021 On any nonzero rsp_err, rsp_instr SHALL be NOP and the memory content SHALL be ignored.
REQ-022 The response buffer SHALL be a 2-entry FIFO, so that sustained 1-fetch-per-cycle throughput holds while rsp_ready is continuously 1.
REQ-023 req_ready SHALL be 1 only when all three hold: load_en is 0, flush is 0, and (buffer occupancy + in-flight) < 2.
REQ-024 With rsp_ready at 0, at most 2 accepted fetches SHALL be held; no response SHALL be lost or duplicated.
REQ-025 Responses SHALL leave in acceptance order; rsp_instr and rsp_err SHALL be stable while rsp_valid is 1 and rsp_ready is 0.
REQ-026 load_en SHALL write load_data to load_addr at the clock edge, including while responses are buffered.
REQ-027 A load and an in-flight read of the same word in the same cycle SHALL return the old data (read-before-write).
REQ-028 flush SHALL empty the buffer and cancel the in-flight read at the clock edge; rsp_valid SHALL be 0 in the following cycle.
REQ-029 flush and req_valid in the same cycle SHALL accept nothing.
REQ-030 rsp_valid SHALL be 1 whenever occupancy > 0; occupancy SHALL never wrap.
REQ-031 A simultaneous push and pop at occupancy 2 SHALL NOT occur, because req_ready is 0 there.

Reset
REQ-032 While rst_n is 0 at a clock edge, occupancy SHALL clear, the in-flight read SHALL be cancelled, rsp_valid SHALL be 0, rsp_instr SHALL be NOP, rsp_err SHALL be 00, and req_ready SHALL be 0.
REQ-033 Memory contents SHALL NOT be reset; a load issued while rst_n is 0 SHALL be ignored.
REQ-034 Reset asserted mid-operation SHALL discard all pending responses with no partial output.
REQ-035 req_ready SHALL be 1 in the first cycle after rst_n rises, provided load_en is 0.

Structure
REQ-036 Shared package imem_pkg SHALL hold the rsp_err code constants (ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_BOTH) and the default NOP.
REQ-037 Storage SHALL be one sub-module, imem_array: one write port, one registered read port, parameters DATA_W and ADDR_W.
REQ-038 Error checks, in-flight tracking and the 2-entry FIFO SHALL live in imem_fetch_buf.

Verification
REQ-039 Scenario 1: load words 0..31 with 32'hA000_0000+i, then fetch pc = 4*i back-to-back with rsp_ready at 1 -> one response per cycle after 1-cycle latency, rsp_instr = 32'hA000_0000+i, rsp_err = 00.
REQ-040 Scenario 2: fetch pc = 32'h6, then pc = 32'h80 (ADDR_W = 5) -> rsp_instr = NOP with rsp_err = 01, then NOP with rsp_err = 10.
REQ-041 Scenario 3: rsp_ready at 0, req_valid held at 1 -> exactly 2 fetches accepted and req_ready = 0; release rsp_ready -> both responses in order, then throughput resumes.
REQ-042 Scenario 4: same-cycle load of word 3 = 32'hDEAD_BEEF and fetch of pc = 32'hC -> old word returned; a repeat fetch of pc = 32'hC -> 32'hDEAD_BEEF.
REQ-043 Scenario 5: 2 responses buffered, pulse flush -> rsp_valid = 0 next cycle; the next fetch returns correct data with 1-cycle latency.
REQ-044 Scenario 6: rst_n driven low with 2 responses buffered -> rsp_valid = 0, rsp_instr = NOP, req_ready = 0 while low; memory retains the loaded words after release.
